// File: rtl/counter_pkg.sv
// Shared constants for the counter: default width, parameter limits and the
// wrap/saturate selection (macro COUNTER_SATURATE_EN).
package counter_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;
  localparam int unsigned WIDTH_MIN     = 1;
  localparam int unsigned WIDTH_MAX     = 32;

  localparam longint unsigned MAX_VALUE_MIN = 64'd1;

`ifdef COUNTER_SATURATE_EN
  localparam bit SATURATE_DEFAULT = 1'b1;
`else
  localparam bit SATURATE_DEFAULT = 1'b0;
`endif

  // Largest count representable in 'width' bits; 64-bit math keeps width=32 exact.
  function automatic longint unsigned max_limit(input int unsigned width);
    return (64'd1 << width) - 64'd1;
  endfunction

endpackage

// File: rtl/counter_next.sv
// Combinational next-state for the counter: hold, increment, terminal-count
// wrap or saturate, and recovery from an out-of-range value.
module counter_next
  import counter_pkg::*;
#(
  parameter int unsigned     WIDTH     = DEFAULT_WIDTH,
  parameter longint unsigned MAX_VALUE = max_limit(WIDTH),
  parameter bit              SATURATE  = SATURATE_DEFAULT
) (
  input  logic [WIDTH-1:0] i_count,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_next
);

  localparam logic [WIDTH-1:0] MAX_V = MAX_VALUE[WIDTH-1:0];

  always_comb begin
    // NOTE: default first so every path assigns o_next and no latch is inferred.
    o_next = i_count;
    if (i_en) begin
      if (i_count > MAX_V) begin
        o_next = '0;
      end else if (i_count == MAX_V) begin
        o_next = SATURATE ? MAX_V : '0;
      end else begin
        o_next = i_count + WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/counter.sv
// Up counter with synchronous active-low reset; wraps at MAX_VALUE, or
// saturates there when COUNTER_SATURATE_EN is defined.
module counter
  import counter_pkg::*;
#(
  parameter int unsigned     WIDTH     = DEFAULT_WIDTH,
  parameter longint unsigned MAX_VALUE = max_limit(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("counter: WIDTH=%0d outside %0d..%0d", WIDTH, WIDTH_MIN, WIDTH_MAX);
  end

  if (MAX_VALUE < MAX_VALUE_MIN || MAX_VALUE > max_limit(WIDTH)) begin : g_bad_max
    $error("counter: MAX_VALUE=%0d outside 1..2**WIDTH-1", MAX_VALUE);
  end

  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_next;

  counter_next #(
    .WIDTH     (WIDTH),
    .MAX_VALUE (MAX_VALUE),
    .SATURATE  (SATURATE_DEFAULT)
  ) u_next (
    .i_count (r_count),
    .i_en    (en),
    .o_next  (w_next)
  );

  // NOTE: sequential state uses <= so all flops sample pre-edge values together.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_count <= '0;
    end else begin
      r_count <= w_next;
    end
  end

  assign count = r_count;

endmodule

// File: tb/tb_counter.sv
// Scoreboard bench: a default counter (A, MAX=15) and a modulo-10 counter (B)
// share stimulus; the driver queues expected values and a monitor checks them.
module tb_counter;

`ifdef COUNTER_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct {
    string      tag;
    logic [3:0] exp_a;
    logic [3:0] exp_b;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en  = 1'b0;
  logic [3:0] count_a;
  logic [3:0] count_b;

  exp_t sb_q[$];
  int   n_pass  = 0;
  int   n_total = 0;
  bit   done    = 1'b0;

  always #5 clk = ~clk;

  counter #(.WIDTH(4)) u_dut_a (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .count (count_a)
  );

  counter #(.WIDTH(4), .MAX_VALUE(9)) u_dut_b (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .count (count_b)
  );

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Drive one edge's inputs and queue what both counters must show after it.
  task automatic step(input logic r, input logic e, input logic [3:0] ea,
                      input logic [3:0] eb, input string tag);
    exp_t item;
    @(negedge clk);
    rst = r;
    en  = e;
    item.tag   = tag;
    item.exp_a = ea;
    item.exp_b = eb;
    sb_q.push_back(item);
  endtask

  initial begin : monitor
    exp_t item;
    while (!done) begin
      @(posedge clk);
      #1;
      if (sb_q.size() != 0) begin
        item = sb_q.pop_front();
        check({item.tag, "_a"}, count_a, item.exp_a);
        check({item.tag, "_b"}, count_b, item.exp_b);
      end
    end
  end

  initial begin : driver
    logic [3:0] wrap_a[3];
    logic [3:0] wrap_b[3];
    int         wait_cycles;

    if (SAT) wrap_a = '{4'd15, 4'd15, 4'd15};
    else     wrap_a = '{4'd15, 4'd0,  4'd1};
    wrap_b = '{4'd5, 4'd6, 4'd7};

    // Reset held with en=1, then release and count.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 4'd0, 4'd0, "reset_hold");
    step(1'b1, 1'b1, 4'd1, 4'd1, "reset_release1");
    step(1'b1, 1'b1, 4'd2, 4'd2, "reset_release2");
    step(1'b1, 1'b1, 4'd3, 4'd3, "reset_release3");

    // Reach 14 on A (B wraps at 9 along the way), then cross the terminal count.
    step(1'b0, 1'b1, 4'd0, 4'd0, "wrap_reset");
    for (int i = 1; i <= 14; i++)
      step(1'b1, 1'b1, 4'(i), 4'(i % 10), "wrap_climb");
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b1, wrap_a[i], wrap_b[i], "wrap_edge");
    step(1'b0, 1'b0, 4'd0, 4'd0, "wrap_then_reset");

    // Enable: count to 5, hold for 4 edges, resume.
    for (int i = 1; i <= 5; i++) step(1'b1, 1'b1, 4'(i), 4'(i), "enable_climb");
    for (int i = 0; i < 4; i++)  step(1'b1, 1'b0, 4'd5, 4'd5, "enable_hold");
    step(1'b1, 1'b1, 4'd6, 4'd6, "enable_resume");

    // Reset beats enable mid-count at 9.
    step(1'b1, 1'b1, 4'd7, 4'd7, "prio_climb7");
    step(1'b1, 1'b1, 4'd8, 4'd8, "prio_climb8");
    step(1'b1, 1'b1, 4'd9, 4'd9, "prio_climb9");
    step(1'b0, 1'b1, 4'd0, 4'd0, "prio_reset");

    // Modulus: two-plus full periods of B against A counting to its own limit.
    for (int i = 1; i <= 21; i++)
      step(1'b1, 1'b1, SAT ? 4'((i > 15) ? 15 : i) : 4'(i % 16), 4'(i % 10), "modulus");

    wait_cycles = 0;
    while (sb_q.size() != 0 && wait_cycles < 20) begin
      @(posedge clk);
      wait_cycles++;
    end
    repeat (2) @(posedge clk);
    done = 1'b1;
    n_total++;
    if (sb_q.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d pending expected 0", sb_q.size());

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/counter.md
COUNTER -- requirements
Module: counter

Interface
REQ-001 Parameter WIDTH, default 4: counter width in bits; legal range 1..32.
REQ-002 Parameter MAX_VALUE, default 2**WIDTH-1: terminal count; legal range 1..2**WIDTH-1.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, synchronous and active-low; reset is asserted while rst=0 at a rising clk edge.
REQ-005 Port en, input, 1 bit: count enable, active-high, sampled on the rising clk edge.
REQ-006 Port count, output, WIDTH bits: current counter value, driven directly from a register.
REQ-007 Port order SHALL be clk, rst, en, count, so positional instantiation works.

Function
REQ-008 On a rising clk edge with rst=0, count SHALL load 0, regardless of en.
REQ-009 On a rising clk edge with rst=1 and en=1, count SHALL advance per REQ-010/REQ-011.
REQ-010 Advance when count < MAX_VALUE: count SHALL become count+1.
REQ-011 Advance when count == MAX_VALUE, default build: count SHALL wrap to 0 on that edge.
REQ-012 On a rising clk edge with rst=1 and en=0, count SHALL hold its value.
REQ-013 Latency: an en or rst change sampled at edge N SHALL be visible on count after edge N, with zero added cycles.
REQ-014 count SHALL change only on rising clk edges; there is no combinational path from en or rst to count.
REQ-015 Arithmetic SHALL be unsigned, modulo 2**WIDTH internally; count SHALL never exceed MAX_VALUE after reset.
REQ-016 If MAX_VALUE < 2**WIDTH-1 and count is out of range (only possible before the first reset), an enabled edge SHALL load 0.

Reset
REQ-017 count is undefined at power-up; reset SHALL be applied for at least one rising clk edge before use.
REQ-018 Reset SHALL take priority over en on the same edge.
REQ-019 Reset mid-count SHALL force count to 0 on the next edge.
REQ-020 After rst returns to 1, the first enabled edge SHALL produce count=1.
REQ-021 No asynchronous reset path SHALL exist.

Configuration
REQ-022 Macro COUNTER_SATURATE_EN defined: at count == MAX_VALUE with en=1, count SHALL hold MAX_VALUE instead of wrapping; all other behaviour is unchanged.
REQ-023 Macro COUNTER_SATURATE_EN undefined: wrap behaviour per REQ-011.

Structure
REQ-024 Shared package counter_pkg SHALL hold the default width constant (4) and the parameter range-check limits.
REQ-025 Sub-module counter_next SHALL compute the next value combinationally from count, en, MAX_VALUE and the saturate option.
REQ-026 The top-level counter SHALL contain only the register, the reset mux and the parameter assertions.
REQ-027 Illegal WIDTH or MAX_VALUE SHALL trigger an elaboration-time error.

Verification
REQ-028 Reset test: rst=0 for 3 edges with en=1 -> count=0 on every edge; rst=1, en=1 -> count 1,2,3 on the next 3 edges.
REQ-029 Wrap test (WIDTH=4, default MAX_VALUE): from count=14 with en=1 -> 15, then 0, then 1.
REQ-030 Enable test: count=5, en=0 for 4 edges -> count stays 5; en=1 -> 6.
REQ-031 Reset priority test: count=9 with rst=0 and en=1 on the same edge -> count=0.
REQ-032 Modulus test (MAX_VALUE=9): counting from 0 -> 0..9,0 repeating, 10-cycle period.
REQ-033 Saturate test (COUNTER_SATURATE_EN, WIDTH=4): from 14 with en=1 -> 15, 15, 15; then rst=0 -> 0.
